data_mem_ctrl: RTL and testbench

//  Byte-addressable, little-endian data memory behind a valid/ready request port and a one-cycle response pulse.

---
 rtl/data_mem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory: valid/ready request, response pulse WAIT_STATES+1 cycles after acceptance,
// one request in flight (Req_Ready low while Busy). Optional misalignment faults under `define DMEM_MISALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_DEPTH  = 2**10,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Req_Valid,
  output logic                     Req_Ready,
  input  logic [ADDRESS_WIDTH-1:0] Req_Addr,
  input  logic [DATA_WIDTH-1:0]    Req_WData,
  input  logic                     Req_Write,
  input  logic [1:0]               Req_Size,
  input  logic                     Req_Unsigned,
  output logic                     Rsp_Valid,
  output logic [DATA_WIDTH-1:0]    Rsp_RData,
  output logic                     Rsp_Err,
  output logic                     Busy
);

  localparam int IW = $clog2(MEMORY_DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     write_q, write_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic                     rsp_vld_q, rsp_vld_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic [7:0]               mem [MEMORY_DEPTH];

  logic                     accept, enter_resp, fault, misalign, out_of_range, mem_we;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [31:0]              a_wdata;
  logic                     a_write, a_uns;
  logic [1:0]               a_size, nm1;
  logic [3:0]               be;
  logic [ADDRESS_WIDTH:0]   last_byte;
  logic [IW-1:0]            idx [4];
  logic [7:0]               rb [4];
  logic [31:0]              ld;

  assign Req_Ready = (state_q == IDLE);
  assign Busy      = (state_q != IDLE);
  assign Rsp_Valid = rsp_vld_q;
  assign Rsp_RData = rdata_q;
  assign Rsp_Err   = err_q;

  assign accept     = Req_Valid && (state_q == IDLE);
  assign enter_resp = ((state_q == WAIT) && (cnt_q == 4'd0)) || (accept && (WAIT_STATES == 0));

  // With zero wait states the access happens on the accepting edge, before the fields are latched.
  always_comb begin
    if (state_q == IDLE) begin
      a_addr  = Req_Addr;
      a_wdata = Req_WData[31:0];
      a_write = Req_Write;
      a_size  = Req_Size;
      a_uns   = Req_Unsigned;
    end else begin
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_write = write_q;
      a_size  = size_q;
      a_uns   = uns_q;
    end
  end

  always_comb begin
    nm1 = 2'd0;
    be  = 4'b0001;
    case (a_size)
      2'b00:   begin nm1 = 2'd3; be = 4'b1111; end
      2'b01:   begin nm1 = 2'd1; be = 4'b0011; end
      default: begin nm1 = 2'd0; be = 4'b0001; end
    endcase
  end

  // Range check in one extra bit so an access near the top of the address space cannot wrap.
  assign last_byte    = {1'b0, a_addr} + {{(ADDRESS_WIDTH-1){1'b0}}, nm1};
  assign out_of_range = last_byte >= (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((a_size == 2'b01) && a_addr[0]) || ((a_size == 2'b00) && (a_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault  = (a_size == 2'b11) || out_of_range || misalign;
  assign mem_we = enter_resp && a_write && !fault && !RST;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i] = a_addr[IW-1:0] + IW'(i);
      rb[i]  = mem[idx[i]];
    end
  end

  always_comb begin
    case (a_size)
      2'b00:   ld = {rb[3], rb[2], rb[1], rb[0]};
      2'b01:   ld = {{16{~a_uns & rb[1][7]}}, rb[1], rb[0]};
      2'b10:   ld = {{24{~a_uns & rb[0][7]}}, rb[0]};
      default: ld = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rsp_vld_d = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = Req_Addr;
          wdata_d = Req_WData[31:0];
          write_d = Req_Write;
          size_d  = Req_Size;
          uns_d   = Req_Unsigned;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rsp_vld_d = 1'b1;
      err_d     = fault;
      rdata_d   = (fault || a_write) ? 32'd0 : ld;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      rsp_vld_q <= rsp_vld_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx[i]] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one instance with two wait states, one with zero wait states, sharing request fields.
module tb_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        vld2 = 1'b0, vld0 = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        wr = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;

  logic        rdy2, rsp2, err2, busy2;
  logic [31:0] rd2;
  logic        rdy0, rsp0, err0, busy0;
  logic [31:0] rd0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] r;
  logic        e;
  int          lat, rlow;
  logic        seen;

  always #5 CLK = ~CLK;

  data_mem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEMORY_DEPTH(1024), .WAIT_STATES(2)) dut2 (
    .CLK(CLK), .RST(RST), .Req_Valid(vld2), .Req_Ready(rdy2), .Req_Addr(addr), .Req_WData(wdata),
    .Req_Write(wr), .Req_Size(size), .Req_Unsigned(uns), .Rsp_Valid(rsp2), .Rsp_RData(rd2),
    .Rsp_Err(err2), .Busy(busy2)
  );

  data_mem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEMORY_DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(RST), .Req_Valid(vld0), .Req_Ready(rdy0), .Req_Addr(addr), .Req_WData(wdata),
    .Req_Write(wr), .Req_Size(size), .Req_Unsigned(uns), .Rsp_Valid(rsp0), .Rsp_RData(rd0),
    .Rsp_Err(err0), .Busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to the selected instance (sel=1 -> zero-wait instance) and wait for its response.
  task automatic do_req(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u,
                        output logic [31:0] rd, output logic er, output int l, output int rl);
    int g;
    g = 0;
    @(negedge CLK);
    while (!(sel ? rdy0 : rdy2) && g < 20) begin
      @(negedge CLK);
      g++;
    end
    wr = w; addr = a; wdata = d; size = sz; uns = u;
    if (sel) vld0 = 1'b1; else vld2 = 1'b1;
    @(posedge CLK); #1;
    vld0 = 1'b0; vld2 = 1'b0;
    addr = 32'h0000_0100; wdata = 32'h0BAD_F00D; wr = ~w; size = 2'b10; uns = ~u;
    l = 1; rl = 0;
    while (!(sel ? rsp0 : rsp2) && l < 40) begin
      if (!(sel ? rdy0 : rdy2)) rl++;
      @(posedge CLK); #1;
      l++;
    end
    if (!(sel ? rdy0 : rdy2)) rl++;
    rd = sel ? rd0 : rd2;
    er = sel ? err0 : err2;
    check("rsp_seen", {31'd0, sel ? rsp0 : rsp2}, 32'd1);
    @(posedge CLK); #1;
    check("rsp_one_cycle", {31'd0, sel ? rsp0 : rsp2}, 32'd0);
    check("ready_after_rsp", {31'd0, sel ? rdy0 : rdy2}, 32'd1);
  endtask

  task automatic op(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] sz, input logic u,
                    input logic [31:0] exp_rd, input logic exp_er, input string tag);
    logic [31:0] q;
    logic        x;
    int          l, rl;
    do_req(sel, w, a, d, sz, u, q, x, l, rl);
    check({tag, "_rdata"}, q, exp_rd);
    check({tag, "_err"}, {31'd0, x}, {31'd0, exp_er});
    check({tag, "_latency"}, l, sel ? 32'd1 : 32'd3);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready2", {31'd0, rdy2}, 32'd1);
    check("rst_busy2",  {31'd0, busy2}, 32'd0);
    check("rst_rsp2",   {31'd0, rsp2}, 32'd0);
    check("rst_rdata2", rd2, 32'd0);
    check("rst_err2",   {31'd0, err2}, 32'd0);
    check("rst_ready0", {31'd0, rdy0}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    // Word store, latency and ready-low window
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, r, e, lat, rlow);
    check("st_word_latency", lat, 32'd3);
    check("st_word_ready_low", rlow, 32'd3);
    check("st_word_err", {31'd0, e}, 32'd0);
    check("st_word_rdata", r, 32'd0);

    // Byte/half loads with extension
    op(1'b0, 1'b0, 32'h13, 32'd0, 2'b10, 1'b0, 32'hFFFFFFDE, 1'b0, "ld_b13_s");
    op(1'b0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'hFFFFFFEF, 1'b0, "ld_b10_s");
    op(1'b0, 1'b0, 32'h13, 32'd0, 2'b10, 1'b1, 32'h000000DE, 1'b0, "ld_b13_u");
    op(1'b0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b1, 32'h000000EF, 1'b0, "ld_b10_u");
    op(1'b0, 1'b0, 32'h12, 32'd0, 2'b01, 1'b0, 32'hFFFFDEAD, 1'b0, "ld_h12_s");
    op(1'b0, 1'b0, 32'h10, 32'd0, 2'b00, 1'b1, 32'hDEADBEEF, 1'b0, "ld_w10");

    // Byte store preserves neighbours
    op(1'b0, 1'b1, 32'h11, 32'hFFFFFF55, 2'b10, 1'b0, 32'd0, 1'b0, "st_b11");
    op(1'b0, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0, 32'hDEAD55EF, 1'b0, "ld_w10_b");

    // Top-of-memory boundary and reserved size
    op(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 2'b00, 1'b0, 32'd0, 1'b0, "st_w1020");
    op(1'b0, 1'b1, 32'd1022, 32'h00000077, 2'b10, 1'b0, 32'd0, 1'b0, "st_b1022");
    op(1'b0, 1'b1, 32'd1023, 32'h00000066, 2'b10, 1'b0, 32'd0, 1'b0, "st_b1023");
    op(1'b0, 1'b0, 32'd1022, 32'd0, 2'b01, 1'b1, 32'h00006677, 1'b0, "ld_h1022");
    op(1'b0, 1'b1, 32'd1022, 32'h12345678, 2'b00, 1'b0, 32'd0, 1'b1, "st_w1022_oor");
    op(1'b0, 1'b0, 32'd1022, 32'd0, 2'b00, 1'b0, 32'd0, 1'b1, "ld_w1022_oor");
    op(1'b0, 1'b0, 32'd1023, 32'd0, 2'b01, 1'b1, 32'd0, 1'b1, "ld_h1023_oor");
    op(1'b0, 1'b0, 32'd1020, 32'd0, 2'b00, 1'b0, 32'h6677F00D, 1'b0, "ld_w1020_kept");
    op(1'b0, 1'b1, 32'h10, 32'h00000000, 2'b11, 1'b0, 32'd0, 1'b1, "st_size11");
    op(1'b0, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 32'd0, 1'b1, "ld_size11");
    op(1'b0, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0, 32'hDEAD55EF, 1'b0, "ld_w10_kept");

    // Misaligned word load
    op(1'b0, 1'b1, 32'h14, 32'h0000009C, 2'b10, 1'b0, 32'd0, 1'b0, "st_b14");
`ifdef DMEM_MISALIGN_CHECK_EN
    op(1'b0, 1'b0, 32'h11, 32'd0, 2'b00, 1'b0, 32'd0, 1'b1, "ld_w11_mis");
`else
    op(1'b0, 1'b0, 32'h11, 32'd0, 2'b00, 1'b0, 32'h9CDEAD55, 1'b0, "ld_w11_mis");
`endif

    // Reset during WAIT drops the store
    op(1'b0, 1'b1, 32'h20, 32'h11223344, 2'b00, 1'b0, 32'd0, 1'b0, "st_w20");
    op(1'b0, 1'b0, 32'h20, 32'd0, 2'b00, 1'b0, 32'h11223344, 1'b0, "ld_w20");
    op(1'b1, 1'b1, 32'h20, 32'h11223344, 2'b00, 1'b0, 32'd0, 1'b0, "z_st_w20");
    @(negedge CLK);
    wr = 1'b1; addr = 32'h20; wdata = 32'hAAAAAAAA; size = 2'b00; uns = 1'b0; vld2 = 1'b1;
    @(posedge CLK); #1;
    vld2 = 1'b0;
    check("abort_busy", {31'd0, busy2}, 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      seen = seen | rsp2;
    end
    check("abort_rst_ready", {31'd0, rdy2}, 32'd1);
    check("abort_rst_busy", {31'd0, busy2}, 32'd0);
    check("abort_rst_rdata", rd2, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      seen = seen | rsp2;
    end
    check("abort_no_rsp", {31'd0, seen}, 32'd0);
    op(1'b0, 1'b0, 32'h20, 32'd0, 2'b00, 1'b0, 32'h11223344, 1'b0, "ld_w20_after_abort");

    // Zero-wait instance: reset on the accepting edge drops the store
    @(negedge CLK);
    wr = 1'b1; addr = 32'h20; wdata = 32'hBBBBBBBB; size = 2'b00; uns = 1'b0; vld0 = 1'b1; RST = 1'b1;
    @(posedge CLK); #1;
    vld0 = 1'b0;
    check("z_abort_no_rsp", {31'd0, rsp0}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    op(1'b1, 1'b0, 32'h20, 32'd0, 2'b00, 1'b0, 32'h11223344, 1'b0, "z_ld_w20");
    op(1'b1, 1'b0, 32'h23, 32'd0, 2'b10, 1'b0, 32'h00000011, 1'b0, "z_ld_b23");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
